// File: rtl/md_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : md_ctrl_if
// Description : Request/response bundle between the execute stage (master)
//               and the multiply/divide controller (slave).
//                 md_valid  - request valid
//                 md_op     - one-hot {mtlo,mthi,mflo,mfhi,divu,div,multu,mult}
//                 md_src1   - rs value (dividend / multiplicand / mthi,mtlo data)
//                 md_src2   - rt value (divisor / multiplier)
//                 md_cancel - abort in-flight mult/div (pipeline flush)
//                 md_ready  - controller can accept a request this cycle
//                 md_rdata  - mfhi/mflo read data, valid in the accept cycle
//                 md_busy   - a mult/div is in flight
//                 hi, lo    - architectural HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
interface md_ctrl_if;
    logic        md_valid;
    logic [7:0]  md_op;
    logic [31:0] md_src1;
    logic [31:0] md_src2;
    logic        md_cancel;
    logic        md_ready;
    logic [31:0] md_rdata;
    logic        md_busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output md_valid, md_op, md_src1, md_src2, md_cancel,
        input  md_ready, md_rdata, md_busy, hi, lo
    );

    modport slave (
        input  md_valid, md_op, md_src1, md_src2, md_cancel,
        output md_ready, md_rdata, md_busy, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/md_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : md_ctrl
// Description : HI/LO multiply/divide controller. Sequences a fixed-latency
//               multiplier (MUL_CYCLES busy cycles) and a 32-iteration
//               restoring divider, owns HI/LO and back-pressures the execute
//               stage through md_ready while an operation is in flight.
// Ports       : clk   - clock
//               reset - synchronous active-high reset
//               md    - md_ctrl_if.slave request/response bundle
// Parameters  : MUL_CYCLES - multiply latency in busy cycles (1..4)
// Revision    : 1.0 - initial release
// ============================================================================
module md_ctrl #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    md_ctrl_if.slave    md
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    localparam logic [5:0] c_mul_cnt = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] c_div_cnt = 6'd31;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_ready;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    // r_opa: multiplicand, or |dividend| shifting out while quotient shifts in
    // r_opb: multiplier, or |divisor|
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [31:0] r_rem;
    logic [31:0] r_src1;
    logic        r_mul_signed;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dvs_zero;

    logic        w_accept;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_div_signed;
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic [63:0] w_prod;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_q_final;
    logic [31:0] w_r_final;
    logic [31:0] w_rdata;

    assign w_accept     = md.md_valid && r_ready;
    assign w_is_mul     = md.md_op[0] | md.md_op[1];
    assign w_is_div     = md.md_op[2] | md.md_op[3];
    assign w_div_signed = md.md_op[2];

    // Magnitudes for the unsigned divider core. |0x80000000| stays
    // 0x80000000, which is the correct unsigned magnitude.
    assign w_abs1 = (w_div_signed && md.md_src1[31]) ? (32'd0 - md.md_src1) : md.md_src1;
    assign w_abs2 = (w_div_signed && md.md_src2[31]) ? (32'd0 - md.md_src2) : md.md_src2;

    // Sign-extending to 64 bits and truncating the product gives the
    // correct signed or unsigned 64-bit result from one multiplier.
    assign w_prod = {{32{r_mul_signed & r_opa[31]}}, r_opa}
                  * {{32{r_mul_signed & r_opb[31]}}, r_opb};

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and subtract the divisor if it fits.
    assign w_rem_sh   = {r_rem, r_opa[31]};
    assign w_diff     = w_rem_sh - {1'b0, r_opb};
    assign w_rem_next = w_diff[32] ? w_rem_sh[31:0] : w_diff[31:0];
    assign w_quo_next = {r_opa[30:0], ~w_diff[32]};

    assign w_q_final = r_neg_q ? (32'd0 - w_quo_next) : w_quo_next;
    assign w_r_final = r_neg_r ? (32'd0 - w_rem_next) : w_rem_next;

    always_comb begin
        w_rdata = 32'd0;
        if (w_accept && md.md_op[4]) begin
            w_rdata = r_hi;
        end else if (w_accept && md.md_op[5]) begin
            w_rdata = r_lo;
        end
    end

    assign md.md_ready = r_ready;
    assign md.md_busy  = r_busy;
    assign md.md_rdata = w_rdata;
    assign md.hi       = r_hi;
    assign md.lo       = r_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 6'd0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_hi         <= 32'd0;
            r_lo         <= 32'd0;
            r_opa        <= 32'd0;
            r_opb        <= 32'd0;
            r_rem        <= 32'd0;
            r_src1       <= 32'd0;
            r_mul_signed <= 1'b0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_dvs_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (md.md_op[6]) r_hi <= md.md_src1;
                        if (md.md_op[7]) r_lo <= md.md_src1;
                        if (w_is_mul) begin
                            r_state      <= S_MUL;
                            r_ready      <= 1'b0;
                            r_busy       <= 1'b1;
                            r_cnt        <= c_mul_cnt;
                            r_opa        <= md.md_src1;
                            r_opb        <= md.md_src2;
                            r_mul_signed <= md.md_op[0];
                        end else if (w_is_div) begin
                            r_state    <= S_DIV;
                            r_ready    <= 1'b0;
                            r_busy     <= 1'b1;
                            r_cnt      <= c_div_cnt;
                            r_opa      <= w_abs1;
                            r_opb      <= w_abs2;
                            r_rem      <= 32'd0;
                            r_src1     <= md.md_src1;
                            r_neg_q    <= w_div_signed && (md.md_src1[31] ^ md.md_src2[31]);
                            r_neg_r    <= w_div_signed && md.md_src1[31];
                            r_dvs_zero <= (md.md_src2 == 32'd0);
                        end
                    end
                end
                S_MUL: begin
                    if (md.md_cancel) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == 6'd0) begin
                        r_hi    <= w_prod[63:32];
                        r_lo    <= w_prod[31:0];
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                S_DIV: begin
                    if (md.md_cancel) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_opa <= w_quo_next;
                        r_rem <= w_rem_next;
                        if (r_cnt == 6'd0) begin
                            // Divide-by-zero bypasses sign correction and
                            // returns the raw dividend as the remainder.
                            if (r_dvs_zero) begin
                                r_lo <= 32'hFFFF_FFFF;
                                r_hi <= r_src1;
                            end else begin
                                r_lo <= w_q_final;
                                r_hi <= w_r_final;
                            end
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 6'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_ctrl
// Description : Self-checking bench for md_ctrl. Directed scenarios plus a
//               randomized sequence checked against a behavioural HI/LO model
//               built on 64-bit integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_ctrl;

    localparam logic [7:0] OP_MULT  = 8'h01;
    localparam logic [7:0] OP_MULTU = 8'h02;
    localparam logic [7:0] OP_DIV   = 8'h04;
    localparam logic [7:0] OP_DIVU  = 8'h08;
    localparam logic [7:0] OP_MFHI  = 8'h10;
    localparam logic [7:0] OP_MFLO  = 8'h20;
    localparam logic [7:0] OP_MTHI  = 8'h40;
    localparam logic [7:0] OP_MTLO  = 8'h80;
    localparam int         MULC     = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_ctrl_if md_if ();

    md_ctrl #(.MUL_CYCLES(MULC)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi     = 32'd0;
    logic [31:0] m_lo     = 32'd0;

    // Architectural effect of one accepted op on {HI,LO}.
    function automatic logic [63:0] model_hilo(input logic [7:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] h,
                                               input logic [31:0] l);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     v, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        v  = {h, l};
        if (op == OP_MULT) begin
            v = sa * sb;
        end else if (op == OP_MULTU) begin
            v = ua * ub;
        end else if (op == OP_DIV || op == OP_DIVU) begin
            if (b == 32'd0) begin
                v = {a, 32'hFFFF_FFFF};
            end else if (op == OP_DIV) begin
                sq = sa / sb;
                sr = sa % sb;
                q  = sq;
                r  = sr;
                v  = {r[31:0], q[31:0]};
            end else begin
                q = ua / ub;
                r = ua % ub;
                v = {r[31:0], q[31:0]};
            end
        end else if (op == OP_MTHI) begin
            v = {a, l};
        end else if (op == OP_MTLO) begin
            v = {h, a};
        end
        return v;
    endfunction

    function automatic int model_busy(input logic [7:0] op);
        if (op == OP_MULT || op == OP_MULTU) return MULC;
        if (op == OP_DIV || op == OP_DIVU)   return 32;
        return 0;
    endfunction

    // Presents one op with the DUT idle (called 1 time unit after an edge),
    // then waits out the busy window and checks HI/LO against the model.
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string name);
        logic [31:0] exp_rd;
        int          n;
        int          exp_busy;
        md_if.md_valid = 1'b1;
        md_if.md_op    = op;
        md_if.md_src1  = a;
        md_if.md_src2  = b;
        #1;
        exp_rd = (op == OP_MFHI) ? m_hi : (op == OP_MFLO) ? m_lo : 32'd0;
        n_checks++;
        if (md_if.md_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready: got %b want 1", name, md_if.md_ready);
        end
        n_checks++;
        if (md_if.md_rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL %s rdata: got %h want %h", name, md_if.md_rdata, exp_rd);
        end
        {m_hi, m_lo} = model_hilo(op, a, b, m_hi, m_lo);
        exp_busy = model_busy(op);
        @(posedge clk); #1;
        md_if.md_valid = 1'b0;
        md_if.md_op    = 8'h00;
        n = 0;
        while (md_if.md_ready !== 1'b1 && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (n != exp_busy) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, n, exp_busy);
        end
        n_checks++;
        if (md_if.hi !== m_hi || md_if.lo !== m_lo) begin
            n_fail++;
            $display("FAIL %s hilo: got %h_%h want %h_%h", name, md_if.hi, md_if.lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        md_if.md_valid   = 1'b0;
        md_if.md_op      = 8'h00;
        md_if.md_src1    = 32'd0;
        md_if.md_src2    = 32'd0;
        md_if.md_cancel  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        n_checks++;
        if (md_if.hi !== 32'd0 || md_if.lo !== 32'd0 || md_if.md_busy !== 1'b0 ||
            md_if.md_ready !== 1'b1 || md_if.md_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b ready=%b rdata=%h want 0/0/0/1/0",
                     md_if.hi, md_if.lo, md_if.md_busy, md_if.md_ready, md_if.md_rdata);
        end
    endtask

    task automatic test_move();
        issue(OP_MTHI, 32'h1234_5678, 32'd0, "mthi");
        issue(OP_MTLO, 32'h9ABC_DEF0, 32'd0, "mtlo");
        issue(OP_MFHI, 32'd0, 32'd0, "mfhi");
        issue(OP_MFLO, 32'd0, 32'd0, "mflo");
        issue(8'h00, 32'hDEAD_BEEF, 32'd1, "nop");
    endtask

    task automatic test_mult();
        issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, "mult_neg1x2");
        n_checks++;
        if (md_if.hi !== 32'hFFFF_FFFF || md_if.lo !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL mult_const: got %h_%h want ffffffff_fffffffe", md_if.hi, md_if.lo);
        end
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, "multu_max_x2");
        n_checks++;
        if (md_if.hi !== 32'h0000_0001 || md_if.lo !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL multu_const: got %h_%h want 00000001_fffffffe", md_if.hi, md_if.lo);
        end
    endtask

    task automatic test_div();
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        n_checks++;
        if (md_if.hi !== 32'hFFFF_FFFF || md_if.lo !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_m7_2_const: got %h_%h want ffffffff_fffffffd", md_if.hi, md_if.lo);
        end
        issue(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        n_checks++;
        if (md_if.hi !== 32'd0 || md_if.lo !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL div_min_m1_const: got %h_%h want 00000000_80000000", md_if.hi, md_if.lo);
        end
        issue(OP_DIVU, 32'd5, 32'd0, "divu_5_0");
        issue(OP_DIV, 32'hFFFF_FFF7, 32'd0, "div_m9_0");
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    endtask

    // mfhi presented three cycles into a divide must wait for completion and
    // then return the freshly written remainder.
    task automatic test_stall();
        int n;
        md_if.md_valid = 1'b1;
        md_if.md_op    = OP_DIVU;
        md_if.md_src1  = 32'd1000;
        md_if.md_src2  = 32'd33;
        {m_hi, m_lo} = model_hilo(OP_DIVU, 32'd1000, 32'd33, m_hi, m_lo);
        @(posedge clk); #1;
        md_if.md_valid = 1'b0;
        md_if.md_op    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        md_if.md_valid = 1'b1;
        md_if.md_op    = OP_MFHI;
        #1;
        n = 0;
        while (md_if.md_ready !== 1'b1 && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (n != 30) begin
            n_fail++;
            $display("FAIL stall_cycles: got %0d want 30", n);
        end
        n_checks++;
        if (md_if.md_rdata !== m_hi) begin
            n_fail++;
            $display("FAIL stall_rdata: got %h want %h", md_if.md_rdata, m_hi);
        end
        @(posedge clk); #1;
        md_if.md_valid = 1'b0;
        md_if.md_op    = 8'h00;
    endtask

    task automatic test_cancel();
        // cancel is ignored in IDLE and does not block a same-cycle mtlo
        md_if.md_cancel = 1'b1;
        issue(OP_MTHI, 32'hAAAA_0000, 32'd0, "mthi_cancel");
        issue(OP_MTLO, 32'hAAAA_0000, 32'd0, "mtlo_cancel");
        md_if.md_cancel = 1'b0;
        md_if.md_valid  = 1'b1;
        md_if.md_op     = OP_DIV;
        md_if.md_src1   = 32'd12345;
        md_if.md_src2   = 32'd7;
        @(posedge clk); #1;
        md_if.md_valid = 1'b0;
        md_if.md_op    = 8'h00;
        repeat (9) @(posedge clk);
        #1;
        md_if.md_cancel = 1'b1;
        @(posedge clk); #1;
        md_if.md_cancel = 1'b0;
        n_checks++;
        if (md_if.md_busy !== 1'b0 || md_if.md_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cancel_idle: got busy=%b ready=%b want 0/1", md_if.md_busy, md_if.md_ready);
        end
        repeat (30) @(posedge clk);
        #1;
        n_checks++;
        if (md_if.hi !== 32'hAAAA_0000 || md_if.lo !== 32'hAAAA_0000) begin
            n_fail++;
            $display("FAIL cancel_hilo: got %h_%h want aaaa0000_aaaa0000", md_if.hi, md_if.lo);
        end
    endtask

    task automatic test_reset_mid();
        md_if.md_valid = 1'b1;
        md_if.md_op    = OP_MULT;
        md_if.md_src1  = 32'd3;
        md_if.md_src2  = 32'd5;
        @(posedge clk); #1;
        md_if.md_valid = 1'b0;
        md_if.md_op    = 8'h00;
        reset          = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        n_checks++;
        if (md_if.hi !== 32'd0 || md_if.lo !== 32'd0 || md_if.md_busy !== 1'b0 ||
            md_if.md_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: got hi=%h lo=%h busy=%b ready=%b want 0/0/0/1",
                     md_if.hi, md_if.lo, md_if.md_busy, md_if.md_ready);
        end
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (md_if.hi !== 32'd0 || md_if.lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_late: got %h_%h want 0_0", md_if.hi, md_if.lo);
        end
    endtask

    task automatic test_random();
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            op = 8'h00;
            op[$urandom_range(0, 7)] = 1'b1;
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 20);
                2:       b = 32'd0 - 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            issue(op, a, b, "random");
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_mult();
        test_div();
        test_stall();
        test_cancel();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
Controller for the shared HI/LO multiply/divide resource, driven by the execute stage. Accepts one-hot mult/multu/div/divu/mfhi/mflo/mthi/mtlo requests and sequences a multi-cycle multiplier and a 32-iteration restoring divider. Owns the HI/LO registers and back-pressures the pipeline via md_ready while an operation is in flight. A cancel input aborts in-flight work on a pipeline flush.

Parameters:
MUL_CYCLES, 2, multiply latency in busy cycles; legal range 1..4.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
md_valid  input  1  request valid from execute stage
md_op  input  8  one-hot {mtlo,mthi,mflo,mfhi,divu,div,multu,mult}, bit 0 = mult
md_src1  input  32  rs value (dividend, multiplicand, or mthi/mtlo data)
md_src2  input  32  rt value (divisor or multiplier)
md_cancel  input  1  abort in-flight mult/div; no HI/LO write
md_ready  output  1  request accepted this cycle when md_valid && md_ready
md_rdata  output  32  mfhi/mflo result, combinational, valid in the accept cycle
md_busy  output  1  state != IDLE
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Only clk and reset (synchronous, active-high); one clock domain.
- Reset: state=IDLE, cnt=0, hi=0, lo=0, md_busy=0, md_ready=1, md_rdata=0.
- States: IDLE, MUL, DIV. Internal registers: cnt[5:0], latched operands, sign flags, divider remainder/quotient shift registers.
- md_ready = (state==IDLE). Any op presented while busy is stalled, including mfhi/mflo/mthi/mtlo.
- accept = md_valid && md_ready. md_op==0 with md_valid high is accepted with no effect. More than one md_op bit set is illegal and not checked.
- mthi/mtlo accepted in cycle T: hi/lo = md_src1 at the edge ending T. State stays IDLE.
- mfhi/mflo accepted in cycle T: md_rdata = hi (or lo) combinationally in T. md_rdata=0 when no mfhi/mflo is accepted.
- mult/multu accepted at T:
  - Latch operands; IDLE->MUL; cnt=MUL_CYCLES-1.
  - MUL occupies cycles T+1..T+MUL_CYCLES; cnt decrements each cycle.
  - At the edge ending cycle with cnt==0: {hi,lo} = 64-bit product (signed for mult, unsigned for multu); state->IDLE.
  - md_ready is 1 again in T+MUL_CYCLES+1. No bypass of the new HI/LO value inside the busy window.
- div/divu accepted at T:
  - Latch |src1| and |src2| (raw values for divu) plus the sign flags; IDLE->DIV; cnt=31.
  - One restoring-division bit per cycle over T+1..T+32.
  - At the edge ending the cnt==0 cycle, write lo=quotient and hi=remainder, then go to IDLE.
  - Signed correction: quotient negated iff the operand signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / -1 (div): lo=0x80000000, hi=0.
  - Divisor == 0 (div or divu): still 32 busy cycles; then lo=0xFFFFFFFF, hi=md_src1 as latched; no sign correction.
- md_cancel:
  - In MUL/DIV: next state IDLE, no hi/lo write; md_ready=1 the following cycle.
  - In IDLE: ignored.
  - Has no effect on an mthi/mtlo being accepted in the same cycle.
- Reset mid-operation: overrides everything; all outputs return to reset values the next cycle.
- Simultaneous completion and new md_valid: the completing cycle has md_ready=0; the new op is accepted the next cycle.

Test Plan:
- Reset, then mthi 0x12345678 and mtlo 0x9ABCDEF0 back-to-back -> both md_ready=1; next-cycle mfhi md_rdata=0x12345678, mflo md_rdata=0x9ABCDEF0.
- mult 0xFFFFFFFF x 0x00000002, MUL_CYCLES=2 -> md_ready=0 for 2 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div -7 / 2 -> exactly 32 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100 / 7 -> lo=14, hi=2. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu 5 / 0 -> 32 busy cycles; lo=0xFFFFFFFF, hi=5.
- mfhi presented 3 cycles into a div -> md_ready stays 0 until completion, then md_rdata equals the new remainder.
- md_cancel at busy cycle 10 of a div with hi=lo=0xAAAA0000 -> hi/lo unchanged, md_busy=0 the next cycle. reset asserted mid-mult -> hi=lo=0, state IDLE.
